cla64_accum_stage: RTL and testbench

//  Sequential multi-operand accumulator built around the 64-bit carry-lookahead adder.

---
 rtl/cla64_accum_stage_pkg.sv | 18 +
 rtl/cla64_accum_stage_cla.sv | 87 ++++++++
 rtl/cla64_accum_stage.sv | 152 +++++++++++++++
 tb/tb_cla64_accum_stage.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla64_accum_stage_pkg.sv
// Shared definitions for the CLA-based burst accumulator: datapath width,
// FSM state encoding and the adder carry-out derivation.
package cla64_accum_stage_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // The adder exports block generate/propagate computed with cin=0.
    function automatic logic cout_of(input logic gg, input logic gp, input logic cin);
        return gg | (gp & cin);
    endfunction

endpackage

// File: rtl/cla64_accum_stage_cla.sv
// 64-bit two-level carry-lookahead adder: 4-bit groups, 16-bit sections,
// lookahead across sections. GG/GP describe the whole word with cin=0.
module cla64_accum_stage_cla
    import cla64_accum_stage_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              GP,
    output logic              GG
);

    logic [WORD_W-1:0] p_s;
    logic [WORD_W-1:0] g_s;
    logic [WORD_W-1:0] c_s;
    logic [15:0]       grp_g_s;
    logic [15:0]       grp_p_s;
    logic [15:0]       grp_c_s;
    logic [3:0]        sec_g_s;
    logic [3:0]        sec_p_s;
    logic [3:0]        sec_c_s;
    logic              word_g_s;

    // Generate/propagate tree, then carries pushed back down from section to bit level.
    always_comb begin
        p_s      = a ^ b;
        g_s      = a & b;
        grp_g_s  = 16'h0000;
        grp_p_s  = 16'h0000;
        grp_c_s  = 16'h0000;
        sec_g_s  = 4'h0;
        sec_p_s  = 4'h0;
        sec_c_s  = 4'h0;
        c_s      = {WORD_W{1'b0}};
        word_g_s = 1'b0;

        for (int i = 0; i < 16; i++) begin
            grp_g_s[i] = 1'b0;
            grp_p_s[i] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                grp_g_s[i] = g_s[4*i+k] | (p_s[4*i+k] & grp_g_s[i]);
                grp_p_s[i] = grp_p_s[i] & p_s[4*i+k];
            end
        end

        for (int j = 0; j < 4; j++) begin
            sec_g_s[j] = 1'b0;
            sec_p_s[j] = 1'b1;
            for (int m = 0; m < 4; m++) begin
                sec_g_s[j] = grp_g_s[4*j+m] | (grp_p_s[4*j+m] & sec_g_s[j]);
                sec_p_s[j] = sec_p_s[j] & grp_p_s[4*j+m];
            end
        end

        sec_c_s[0] = cin;
        for (int j = 0; j < 3; j++) begin
            sec_c_s[j+1] = sec_g_s[j] | (sec_p_s[j] & sec_c_s[j]);
        end

        for (int j = 0; j < 4; j++) begin
            grp_c_s[4*j] = sec_c_s[j];
            for (int m = 0; m < 3; m++) begin
                grp_c_s[4*j+m+1] = grp_g_s[4*j+m] | (grp_p_s[4*j+m] & grp_c_s[4*j+m]);
            end
        end

        for (int i = 0; i < 16; i++) begin
            c_s[4*i] = grp_c_s[i];
            for (int k = 0; k < 3; k++) begin
                c_s[4*i+k+1] = g_s[4*i+k] | (p_s[4*i+k] & c_s[4*i+k]);
            end
        end

        for (int j = 0; j < 4; j++) begin
            word_g_s = sec_g_s[j] | (sec_p_s[j] & word_g_s);
        end
    end

    // Sum and word-level lookahead terms.
    always_comb begin
        s  = p_s ^ c_s;
        GP = &p_s;
        GG = word_g_s;
    end

endmodule

// File: rtl/cla64_accum_stage.sv
// Burst accumulator: adds/subtracts a stream of 64-bit operands through the CLA,
// tracks carries minus borrows in a signed extension counter, emits one result beat.
module cla64_accum_stage
    import cla64_accum_stage_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int EXT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [EXT_W-1:0]  out_ext,
    output logic              out_ovf
);

    localparam logic [EXT_W-1:0] EXT_MAX = {1'b0, {(EXT_W-1){1'b1}}};
    localparam logic [EXT_W-1:0] EXT_MIN = {1'b1, {(EXT_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [EXT_W-1:0]  ext_q, ext_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              xfer_s;
    logic [WORD_W-1:0] b_s;
    logic [WORD_W-1:0] s_s;
    logic              cin_s;
    logic              gp_s;
    logic              gg_s;
    logic              cout_s;
    logic              ext_up_s;
    logic              ext_dn_s;

    // Subtraction is acc + ~data + 1, so a carry-out means "no borrow".
    always_comb begin
        xfer_s = in_valid & (state_q == ST_ACCUM);
        b_s    = in_sub ? ~in_data : in_data;
        cin_s  = in_sub;
    end

    cla64_accum_stage_cla u_cla_64bit (
        .a   (acc_q),
        .b   (b_s),
        .cin (cin_s),
        .s   (s_s),
        .GP  (gp_s),
        .GG  (gg_s)
    );

    // Classify the transfer as a carry (ext+1) or a borrow (ext-1).
    always_comb begin
        cout_s   = cout_of(gg_s, gp_s, cin_s);
        ext_up_s = xfer_s & ~in_sub & cout_s;
        ext_dn_s = xfer_s & in_sub & ~cout_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ext_d   = ext_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = {WORD_W{1'b0}};
                    ext_d = {EXT_W{1'b0}};
                    ovf_d = 1'b0;
                    cnt_d = len;
                    if (len != {LEN_W{1'b0}}) begin
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (xfer_s) begin
                    acc_d = s_s;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (ext_up_s) begin
                        ext_d = ext_q + EXT_W'(1);
                        ovf_d = ovf_q | (ext_q == EXT_MAX);
                    end else if (ext_dn_s) begin
                        ext_d = ext_q - EXT_W'(1);
                        ovf_d = ovf_q | (ext_q == EXT_MIN);
                    end else begin
                        ext_d = ext_q;
                    end
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state in one register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= {WORD_W{1'b0}};
            ext_q   <= {EXT_W{1'b0}};
            cnt_q   <= {LEN_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decode straight from registered state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_DONE);
        out_sum   = acc_q;
        out_ext   = ext_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_cla64_accum_stage.sv
// Bench for cla64_accum_stage: two instances (EXT_W=8 and EXT_W=2) on one stimulus
// stream, checked every cycle against an exact-integer model of the running total.
module tb_cla64_accum_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b0;

    logic        busy8, ready8, valid8, ovf8;
    logic [63:0] sum8;
    logic [7:0]  ext8;
    logic        busy2, ready2, valid2, ovf2;
    logic [63:0] sum2;
    logic [1:0]  ext2;

    always #5 clk = ~clk;

    cla64_accum_stage #(.LEN_W(8), .EXT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy8),
        .in_valid(in_valid), .in_ready(ready8), .in_data(in_data), .in_sub(in_sub),
        .out_valid(valid8), .out_ready(out_ready), .out_sum(sum8), .out_ext(ext8),
        .out_ovf(ovf8)
    );

    cla64_accum_stage #(.LEN_W(8), .EXT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy2),
        .in_valid(in_valid), .in_ready(ready2), .in_data(in_data), .in_sub(in_sub),
        .out_valid(valid2), .out_ready(out_ready), .out_sum(sum2), .out_ext(ext2),
        .out_ovf(ovf2)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the burst total as an exact signed integer; sum and extension are its slices.
    typedef enum int {P_IDLE, P_ACCUM, P_DONE} phase_t;
    phase_t               m_phase;
    int                   m_left;
    logic signed [127:0]  m_total;
    bit                   m_ovf8, m_ovf2;

    function automatic logic signed [127:0] step(input logic signed [127:0] t,
                                                 input logic [63:0] d, input logic sub);
        logic signed [127:0] op;
        op = $signed({64'd0, d});
        return sub ? (t - op) : (t + op);
    endfunction

    function automatic bit out_of_range(input logic signed [127:0] t, input int w);
        logic signed [127:0] e;
        e = t >>> 64;
        return (e > ((128'sd1 <<< (w - 1)) - 128'sd1)) || (e < -(128'sd1 <<< (w - 1)));
    endfunction

    function automatic logic [7:0] ext_of(input logic signed [127:0] t);
        logic signed [127:0] e;
        e = t >>> 64;
        return e[7:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE;
            m_left  <= 0;
            m_total <= '0;
            m_ovf8  <= 1'b0;
            m_ovf2  <= 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_total <= '0;
                    m_ovf8  <= 1'b0;
                    m_ovf2  <= 1'b0;
                    m_left  <= int'(len);
                    m_phase <= (len == 8'd0) ? P_DONE : P_ACCUM;
                end
                P_ACCUM: if (in_valid) begin
                    m_total <= step(m_total, in_data, in_sub);
                    if (out_of_range(step(m_total, in_data, in_sub), 8)) m_ovf8 <= 1'b1;
                    if (out_of_range(step(m_total, in_data, in_sub), 2)) m_ovf2 <= 1'b1;
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= P_DONE;
                end
                P_DONE: if (out_ready) m_phase <= P_IDLE;
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", busy8, m_phase != P_IDLE);
            check("in_ready8", ready8, m_phase == P_ACCUM);
            check("out_valid8", valid8, m_phase == P_DONE);
            check("out_sum8", sum8, m_total[63:0]);
            check("out_ext8", ext8, ext_of(m_total));
            check("out_ovf8", ovf8, m_ovf8);
            check("busy2", busy2, m_phase != P_IDLE);
            check("in_ready2", ready2, m_phase == P_ACCUM);
            check("out_valid2", valid2, m_phase == P_DONE);
            check("out_sum2", sum2, m_total[63:0]);
            check("out_ext2", {6'd0, ext2}, ext_of(m_total) & 8'h03);
            check("out_ovf2", ovf2, m_ovf2);
        end
    end

    task automatic start_burst(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'($urandom);
    endtask

    task automatic feed(input logic [63:0] d, input logic sub, input int gap);
        bit ok = 1'b0;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            in_sub   = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready8) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_sub   = 1'($urandom);
        check("feed_handshake", ok, 1'b1);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (valid8) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("result_timeout", ok, 1'b1);
    endtask

    task automatic retire(input int hold, input bit start_in_done, input bit start_with_ready);
        wait_valid();
        for (int k = 0; k < hold; k++) begin
            start = (start_in_done && k == 1);
            len   = 8'd3;
            @(posedge clk); #1;
        end
        start     = start_with_ready;
        len       = 8'd2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 3))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
            1:       return 64'($urandom_range(0, 100));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", busy8, 1'b0);
        check("reset_valid", valid8, 1'b0);
        check("reset_sum", sum8, 64'd0);

        // Reset in the middle of a burst aborts it.
        start_burst(8'd4);
        feed(64'd11, 1'b0, 0);
        feed(64'd22, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy8, 1'b0);
        check("midrst_valid", valid8, 1'b0);
        check("midrst_sum", sum8, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain add, back-to-back.
        start_burst(8'd3);
        feed(64'd1, 1'b0, 0);
        feed(64'd2, 1'b0, 0);
        feed(64'd3, 1'b0, 0);
        @(negedge clk);
        check("add_valid_latency", valid8, 1'b1);
        check("add_sum", sum8, 64'd6);
        check("add_ext", ext8, 8'd0);
        check("add_ovf", ovf8, 1'b0);
        retire(0, 1'b0, 1'b0);

        // Carry into the extension.
        start_burst(8'd2);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        feed(64'h2, 1'b0, 0);
        wait_valid();
        check("carry_sum", sum8, 64'd1);
        check("carry_ext", ext8, 8'd1);
        retire(0, 1'b0, 1'b0);

        // Borrow out of the extension.
        start_burst(8'd2);
        feed(64'd5, 1'b0, 0);
        feed(64'd7, 1'b1, 0);
        wait_valid();
        check("borrow_sum", sum8, 64'hFFFF_FFFF_FFFF_FFFE);
        check("borrow_ext8", ext8, 8'hFF);
        check("borrow_ext2", ext2, 2'b11);
        retire(0, 1'b0, 1'b0);

        // Same operands with input stalls, held result, start pulsed in DONE.
        start_burst(8'd3);
        feed(64'd1, 1'b0, 1);
        feed(64'd2, 1'b0, 1);
        feed(64'd3, 1'b0, 1);
        wait_valid();
        check("stall_sum", sum8, 64'd6);
        retire(5, 1'b1, 1'b1);
        @(negedge clk);
        check("start_with_ready_ignored", busy8, 1'b0);

        // Zero-length burst.
        @(posedge clk); #1;
        start_burst(8'd0);
        @(negedge clk);
        check("len0_valid", valid8, 1'b1);
        check("len0_sum", sum8, 64'd0);
        retire(1, 1'b0, 1'b0);

        // Extension wrap on the narrow instance.
        start_burst(8'd3);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        wait_valid();
        check("wrap_sum", sum2, 64'hFFFF_FFFF_FFFF_FFFD);
        check("wrap_ext2", ext2, 2'b10);
        check("wrap_ovf2", ovf2, 1'b1);
        check("wrap_ext8", ext8, 8'd2);
        check("wrap_ovf8", ovf8, 1'b0);
        retire(0, 1'b0, 1'b0);

        // Randomised bursts; in_valid also pulsed while idle.
        for (int b = 0; b < 40; b++) begin
            int n;
            n = $urandom_range(1, 12);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            in_valid = 1'b0;
            start_burst(8'(n));
            for (int i = 0; i < n; i++) begin
                feed(pick_operand(), 1'($urandom), $urandom_range(0, 2));
            end
            retire($urandom_range(0, 4), 1'($urandom), 1'($urandom));
            @(posedge clk); #1;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
